// File: rtl/auth_pkg.sv
// Shared types and default command bytes for the BLE authentication block.
package auth_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        ON       = 3'd2,
        STOPPING = 3'd3,
        LOCKED   = 3'd4
    } auth_state_e;

    localparam logic [7:0] CMD_GO_DEF   = 8'h47;
    localparam logic [7:0] CMD_STOP_DEF = 8'h53;

endpackage

// File: rtl/auth_token_blk_uart_rx.sv
// 8N1 UART receiver; rdy stays high until clr_rdy, rx_data holds the last good byte.
module UART_rx #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic          rx_ff1, rx_ff2;
    logic          busy;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud_cnt;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1 <= 1'b1;
            rx_ff2 <= 1'b1;
        end else begin
            rx_ff1 <= RX;
            rx_ff2 <= rx_ff1;
        end
    end

    // First wait is half a bit so every later sample lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            bit_cnt  <= 4'd0;
            baud_cnt <= '0;
            shreg    <= 8'h00;
            rx_data  <= 8'h00;
            rdy      <= 1'b0;
        end else begin
            if (clr_rdy)
                rdy <= 1'b0;
            if (!busy) begin
                if (!rx_ff2) begin
                    busy     <= 1'b1;
                    bit_cnt  <= 4'd0;
                    baud_cnt <= BW'(BAUD_DIV / 2);
                end
            end else if (baud_cnt != '0) begin
                baud_cnt <= baud_cnt - 1'b1;
            end else begin
                baud_cnt <= BW'(BAUD_DIV - 1);
                if (bit_cnt == 4'd9) begin
                    busy <= 1'b0;
                    if (rx_ff2) begin
                        rx_data <= shreg;
                        rdy     <= 1'b1;
                    end
                end else if (bit_cnt == 4'd0) begin
                    if (rx_ff2)
                        busy <= 1'b0;
                    else
                        bit_cnt <= 4'd1;
                end else begin
                    shreg   <= {rx_ff2, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/auth_token_blk.sv
// BLE power-up authentication: GO + key bytes enable the segway, with
// inter-byte timeout, failure counting and timed lockout.
module auth_token_blk
    import auth_pkg::*;
#(
    parameter int          KEY_LEN     = 2,
    parameter logic [31:0] KEY         = 32'h0000_A55A,
    parameter logic [7:0]  CMD_GO      = CMD_GO_DEF,
    parameter logic [7:0]  CMD_STOP    = CMD_STOP_DEF,
    parameter int          TIMEOUT_CYC = 5_000_000,
    parameter int          MAX_FAIL    = 3,
    parameter int          LOCK_CYC    = 50_000_000,
    parameter int          BAUD_DIV    = 5208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic RX,
    input  logic rider_off,
    output logic pwr_up,
    output logic locked,
    output logic auth_fail
);

    localparam int IDX_W  = (KEY_LEN > 1)     ? $clog2(KEY_LEN)     : 1;
    localparam int TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int FAIL_W = (MAX_FAIL > 1)    ? $clog2(MAX_FAIL)    : 1;
    localparam int LOCK_W = (LOCK_CYC > 1)    ? $clog2(LOCK_CYC)    : 1;

    logic [7:0]       rx_data;
    logic             rdy;
    logic             clr_rdy;

    auth_state_e      state, nxt;
    logic [IDX_W-1:0] idx;
    logic             mism;
    logic [TMR_W-1:0] tmr;
    logic [FAIL_W-1:0] fail_cnt;
    logic [LOCK_W-1:0] lock_cnt;

    logic             fail_evt;
    logic             byte_bad;
    logic             last_byte;
    logic             lock_now;

    function automatic logic [7:0] key_byte(input logic [IDX_W-1:0] i);
        return KEY[{i, 3'b000} +: 8];
    endfunction

    // Every byte is consumed the cycle it appears, whatever the state does with it.
    assign clr_rdy = rdy;

    UART_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy)
    );

    assign byte_bad  = (rx_data != key_byte(idx));
    assign last_byte = (idx == IDX_W'(KEY_LEN - 1));
    assign lock_now  = (fail_cnt == FAIL_W'(MAX_FAIL - 1));

    always_comb begin
        nxt      = state;
        fail_evt = 1'b0;
        case (state)
            IDLE: begin
                if (rdy && rx_data == CMD_GO)
                    nxt = COLLECT;
            end
            COLLECT: begin
                // The verdict waits for the full key so timing reveals nothing.
                if (rdy) begin
                    if (last_byte) begin
                        if (mism || byte_bad)
                            fail_evt = 1'b1;
                        else
                            nxt = ON;
                    end
                end else if (tmr == TMR_W'(TIMEOUT_CYC - 1)) begin
                    fail_evt = 1'b1;
                end
            end
            ON: begin
                if (rdy && rx_data == CMD_STOP)
                    nxt = STOPPING;
            end
            STOPPING: begin
                if (rider_off)
                    nxt = IDLE;
                else if (rdy && rx_data == CMD_GO)
                    nxt = ON;
            end
            LOCKED: begin
                if (lock_cnt == LOCK_W'(LOCK_CYC - 1))
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (fail_evt)
            nxt = lock_now ? LOCKED : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pwr_up    <= 1'b0;
            locked    <= 1'b0;
            auth_fail <= 1'b0;
            idx       <= '0;
            mism      <= 1'b0;
            tmr       <= '0;
            fail_cnt  <= '0;
            lock_cnt  <= '0;
        end else begin
            state     <= nxt;
            pwr_up    <= (nxt == ON) || (nxt == STOPPING);
            locked    <= (nxt == LOCKED);
            auth_fail <= fail_evt;

            if (state == IDLE && nxt == COLLECT) begin
                idx  <= '0;
                mism <= 1'b0;
            end else if (state == COLLECT && rdy) begin
                idx  <= idx + 1'b1;
                mism <= mism | byte_bad;
            end

            if (state == COLLECT && !rdy)
                tmr <= tmr + 1'b1;
            else
                tmr <= '0;

            // The counter holds at MAX_FAIL-1 through lockout and clears on exit.
            if (fail_evt && !lock_now)
                fail_cnt <= fail_cnt + 1'b1;
            else if (state == COLLECT && nxt == ON)
                fail_cnt <= '0;
            else if (state == LOCKED && nxt == IDLE)
                fail_cnt <= '0;

            if (state == LOCKED)
                lock_cnt <= lock_cnt + 1'b1;
            else
                lock_cnt <= '0;
        end
    end

endmodule
